dual_port_mem_ctrl: RTL and testbench

//  Parametrised successor to the 16x32K Memory_Management store: true dual-clocked-once RAM,

---
 rtl/mem_pkg.sv | 13 +
 rtl/dp_ram_core.sv | 52 +++++
 rtl/dual_port_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dual_port_mem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port memory controller: collision policy codes
// and the controller state type.
package mem_pkg;

    localparam int unsigned COLL_READ_FIRST  = 0;
    localparam int unsigned COLL_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/dp_ram_core.sv
// Synchronous 1W/2R word array with byte-write enables and one registered read per port.
// Port A read returns the merged write word; port B can be steered to it for write-first collisions.
module dp_ram_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [ADDR_W-1:0]     i_addr_a,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_re_a,
    input  logic                  i_re_b,
    input  logic [ADDR_W-1:0]     i_addr_b,
    input  logic                  i_bypass_b,
    output logic [DATA_W-1:0]     o_rdata_a,
    output logic [DATA_W-1:0]     o_rdata_b
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic [DATA_W-1:0] w_merged;

    // Word as it will look after this edge's write; equals the stored word when not writing.
    always_comb begin
        w_merged = r_mem[i_addr_a];
        for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (i_we && i_be[i]) begin
                w_merged[8*i +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr_a][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_re_a) begin
            r_rdata_a <= w_merged;
        end
        if (i_re_b) begin
            r_rdata_b <= i_bypass_b ? w_merged : r_mem[i_addr_b];
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/dual_port_mem_ctrl.sv
// Dual-port memory controller: port A load/store with byte enables, port B fetch read,
// post-reset clear sequencer, collision policy and 1- or 2-cycle read latency.
module dual_port_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned ADDR_W         = 15,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned COLLISION_MODE = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enA,
    input  logic                  wenA,
    input  logic [DATA_W/8-1:0]   beA,
    input  logic [ADDR_W-1:0]     AddressA,
    input  logic [DATA_W-1:0]     WriteDataA,
    output logic [DATA_W-1:0]     ReadDataA,
    output logic                  validA,
    input  logic                  enB,
    input  logic [ADDR_W-1:0]     AddressB,
    output logic [DATA_W-1:0]     ReadDataB,
    output logic                  validB,
    output logic                  busy,
    output logic                  collision
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                w_run;
    logic                w_we;
    logic                w_re_a;
    logic                w_re_b;
    logic                w_coll;
    logic                w_bypass;
    logic [ADDR_W-1:0]   w_addr_a;
    logic [DATA_W/8-1:0] w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_core_rd_a;
    logic [DATA_W-1:0]   w_core_rd_b;
    logic                r_v1_a;
    logic                r_v1_b;
    logic                r_coll1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            CLEAR: begin
                busy = 1'b1;
                if (r_clr_addr == '1) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // While clearing, the port A write path is borrowed to store zeros at the counter address.
    always_comb begin
        w_run    = (r_state == RUN);
        w_we     = busy | (w_run & enA & wenA);
        w_addr_a = w_run ? AddressA : r_clr_addr;
        w_be     = w_run ? beA : '1;
        w_wdata  = w_run ? WriteDataA : '0;
        w_re_a   = w_run & enA;
        w_re_b   = w_run & enB;
        w_coll   = w_run & enA & wenA & enB & (AddressA == AddressB);
        w_bypass = w_coll & (COLLISION_MODE == COLL_WRITE_FIRST);
    end

    dp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .i_clk      (clk),
        .i_we       (w_we),
        .i_be       (w_be),
        .i_addr_a   (w_addr_a),
        .i_wdata    (w_wdata),
        .i_re_a     (w_re_a),
        .i_re_b     (w_re_b),
        .i_addr_b   (AddressB),
        .i_bypass_b (w_bypass),
        .o_rdata_a  (w_core_rd_a),
        .o_rdata_b  (w_core_rd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1_a  <= 1'b0;
            r_v1_b  <= 1'b0;
            r_coll1 <= 1'b0;
        end else begin
            r_v1_a  <= w_re_a;
            r_v1_b  <= w_re_b;
            r_coll1 <= w_coll;
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        // The core read registers are not reset, so mask them until they have been loaded.
        logic r_seen_a;
        logic r_seen_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_seen_a <= 1'b0;
                r_seen_b <= 1'b0;
            end else begin
                r_seen_a <= r_seen_a | r_v1_a;
                r_seen_b <= r_seen_b | r_v1_b;
            end
        end

        assign ReadDataA = (r_v1_a | r_seen_a) ? w_core_rd_a : '0;
        assign ReadDataB = (r_v1_b | r_seen_b) ? w_core_rd_b : '0;
        assign validA    = r_v1_a;
        assign validB    = r_v1_b;
        assign collision = r_coll1;
    end else begin : g_lat2
        logic              r_v2_a;
        logic              r_v2_b;
        logic              r_coll2;
        logic [DATA_W-1:0] r_out_a;
        logic [DATA_W-1:0] r_out_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2_a  <= 1'b0;
                r_v2_b  <= 1'b0;
                r_coll2 <= 1'b0;
                r_out_a <= '0;
                r_out_b <= '0;
            end else begin
                r_v2_a  <= r_v1_a;
                r_v2_b  <= r_v1_b;
                r_coll2 <= r_coll1;
                if (r_v1_a) begin
                    r_out_a <= w_core_rd_a;
                end
                if (r_v1_b) begin
                    r_out_b <= w_core_rd_b;
                end
            end
        end

        assign ReadDataA = r_out_a;
        assign ReadDataB = r_out_b;
        assign validA    = r_v2_a;
        assign validB    = r_v2_b;
        assign collision = r_coll2;
    end

endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Bench for dual_port_mem_ctrl: two instances (latency 1 / read-first, latency 2 / write-first)
// share one stimulus stream and are compared against a word-array reference model every cycle.
module tb_dual_port_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enA = 1'b0;
    logic        wenA = 1'b0;
    logic [1:0]  beA = 2'b00;
    logic [3:0]  AddressA = 4'h0;
    logic [15:0] WriteDataA = 16'h0;
    logic        enB = 1'b0;
    logic [3:0]  AddressB = 4'h0;

    logic [15:0] rdA [2];
    logic [15:0] rdB [2];
    logic        vA [2];
    logic        vB [2];
    logic        bsy [2];
    logic        col [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_port_mem_ctrl #(
        .DATA_W(16), .ADDR_W(4), .RD_LATENCY(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enA(enA), .wenA(wenA), .beA(beA), .AddressA(AddressA),
        .WriteDataA(WriteDataA), .ReadDataA(rdA[0]), .validA(vA[0]), .enB(enB),
        .AddressB(AddressB), .ReadDataB(rdB[0]), .validB(vB[0]), .busy(bsy[0]),
        .collision(col[0])
    );

    dual_port_mem_ctrl #(
        .DATA_W(16), .ADDR_W(4), .RD_LATENCY(2), .COLLISION_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enA(enA), .wenA(wenA), .beA(beA), .AddressA(AddressA),
        .WriteDataA(WriteDataA), .ReadDataA(rdA[1]), .validA(vA[1]), .enB(enB),
        .AddressB(AddressB), .ReadDataB(rdB[1]), .validB(vB[1]), .busy(bsy[1]),
        .collision(col[1])
    );

    // Reference model: plain word array, a clear countdown, and per-instance latency delay.
    typedef struct packed {
        logic        va;
        logic [15:0] da;
        logic        vb;
        logic [15:0] db;
        logic        coll;
    } rsp_t;

    logic [15:0] mmem [16];
    int          busy_cnt;
    rsp_t        pend [2];
    logic [15:0] heldA [2];
    logic [15:0] heldB [2];
    logic        expVA [2];
    logic        expVB [2];
    logic        expColl [2];
    int          LAT [2] = '{1, 2};
    int          MODE [2] = '{0, 1};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        enA = 1'b0; wenA = 1'b0; beA = 2'b00; AddressA = 4'h0; WriteDataA = 16'h0;
        enB = 1'b0; AddressB = 4'h0;
    endtask

    task automatic tick();
        rsp_t        now;
        rsp_t        out;
        logic [15:0] old_b;
        logic [15:0] neww;
        logic        hit;
        for (int d = 0; d < 2; d++) begin
            now = '0;
            if (busy_cnt == 0) begin
                old_b = mmem[AddressB];
                neww  = mmem[AddressA];
                for (int k = 0; k < 2; k++)
                    if (enA && wenA && beA[k]) neww[8*k +: 8] = WriteDataA[8*k +: 8];
                hit = enA && wenA && enB && (AddressA == AddressB);
                now.va   = enA;
                now.da   = neww;
                now.vb   = enB;
                now.db   = (hit && MODE[d] == 1) ? neww : old_b;
                now.coll = hit;
            end
            out = (LAT[d] == 1) ? now : pend[d];
            pend[d] = now;
            expVA[d] = out.va;
            expVB[d] = out.vb;
            expColl[d] = out.coll;
            if (out.va) heldA[d] = out.da;
            if (out.vb) heldB[d] = out.db;
        end
        if (busy_cnt == 0) begin
            if (enA && wenA) mmem[AddressA] = neww;
        end else begin
            busy_cnt--;
            if (busy_cnt == 0)
                for (int i = 0; i < 16; i++) mmem[i] = 16'h0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), {15'b0, bsy[d]}, {15'b0, (busy_cnt > 0)});
            chk($sformatf("validA%0d", d), {15'b0, vA[d]}, {15'b0, expVA[d]});
            chk($sformatf("ReadDataA%0d", d), rdA[d], heldA[d]);
            chk($sformatf("validB%0d", d), {15'b0, vB[d]}, {15'b0, expVB[d]});
            chk($sformatf("ReadDataB%0d", d), rdB[d], heldB[d]);
            chk($sformatf("collision%0d", d), {15'b0, col[d]}, {15'b0, expColl[d]});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        busy_cnt = 16;
        for (int d = 0; d < 2; d++) begin
            pend[d] = '0; heldA[d] = 16'h0; heldB[d] = 16'h0;
            expVA[d] = 1'b0; expVB[d] = 1'b0; expColl[d] = 1'b0;
            chk($sformatf("rst_ReadDataA%0d", d), rdA[d], 16'h0);
            chk($sformatf("rst_ReadDataB%0d", d), rdB[d], 16'h0);
            chk($sformatf("rst_valid%0d", d), {14'b0, vA[d], vB[d]}, 16'h0);
            chk($sformatf("rst_collision%0d", d), {15'b0, col[d]}, 16'h0);
            chk($sformatf("rst_busy%0d", d), {15'b0, bsy[d]}, 16'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (bsy[0] === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(name, n[15:0], 16'd16);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  be;
        logic [3:0]  aA;
        logic [15:0] wd;
        logic        rd;
        logic [3:0]  aB;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        coll;
    } vec_t;

    vec_t vt [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q0 [$];
        logic [15:0] q1 [$];
        int          first0;
        int          last0;
        int          coll_seen;

        vt[0] = '{1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vt[1] = '{1'b1, 2'b01, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vt[2] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd5, 16'hBE34, 16'hBE34, 1'b0};
        vt[3] = '{1'b1, 2'b11, 4'd7, 16'h0001, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0};
        vt[4] = '{1'b1, 2'b11, 4'd7, 16'h00FF, 1'b1, 4'd7, 16'h0001, 16'h00FF, 1'b1};
        vt[5] = '{1'b1, 2'b10, 4'd9, 16'hABCD, 1'b1, 4'd5, 16'hBE34, 16'hBE34, 1'b0};
        vt[6] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd9, 16'hAB00, 16'hAB00, 1'b0};
        vt[7] = '{1'b1, 2'b00, 4'd7, 16'hFFFF, 1'b1, 4'd7, 16'h00FF, 16'h00FF, 1'b1};

        set_idle();
        do_reset();

        // Clear sequence length, then every word reads back as zero on both ports.
        wait_clear("clear_cycles");
        for (int a = 0; a < 16; a++) begin
            enA = 1'b1; AddressA = a[3:0]; enB = 1'b1; AddressB = a[3:0];
            tick();
        end
        set_idle();
        tick();
        tick();

        // Directed vector table: byte merge and collision policy.
        for (int i = 0; i < 8; i++) begin
            enA = vt[i].wr; wenA = vt[i].wr; beA = vt[i].be; AddressA = vt[i].aA;
            WriteDataA = vt[i].wd; enB = vt[i].rd; AddressB = vt[i].aB;
            tick();
            if (vt[i].rd) begin
                chk($sformatf("vec%0d_validB0", i), {15'b0, vB[0]}, 16'h1);
                chk($sformatf("vec%0d_dataB0", i), rdB[0], vt[i].exp0);
                chk($sformatf("vec%0d_coll0", i), {15'b0, col[0]}, {15'b0, vt[i].coll});
            end
            set_idle();
            tick();
            if (vt[i].rd) begin
                chk($sformatf("vec%0d_validB1", i), {15'b0, vB[1]}, 16'h1);
                chk($sformatf("vec%0d_dataB1", i), rdB[1], vt[i].exp1);
                chk($sformatf("vec%0d_coll1", i), {15'b0, col[1]}, {15'b0, vt[i].coll});
            end
        end

        // Back-to-back B reads of addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            enA = 1'b1; wenA = 1'b1; beA = 2'b11; AddressA = i[3:0];
            WriteDataA = 16'h1100 + 16'(i);
            tick();
        end
        set_idle();
        tick();
        first0 = -1; last0 = -1;
        for (int t = 0; t < 7; t++) begin
            enB = (t < 4); AddressB = t[3:0];
            tick();
            if (vB[0]) begin
                q0.push_back(rdB[0]);
                if (first0 < 0) first0 = t;
                last0 = t;
            end
            if (vB[1]) q1.push_back(rdB[1]);
        end
        set_idle();
        chk("b2b_count0", 16'(q0.size()), 16'd4);
        chk("b2b_count1", 16'(q1.size()), 16'd4);
        chk("b2b_span0", 16'(last0 - first0), 16'd3);
        for (int k = 0; k < 4; k++) begin
            if (k < q0.size()) chk($sformatf("b2b_data0_%0d", k), q0[k], 16'h1100 + 16'(k));
            if (k < q1.size()) chk($sformatf("b2b_data1_%0d", k), q1[k], 16'h1100 + 16'(k));
        end

        // Sweep: A writes j while B reads j-1; never a collision.
        q0.delete(); q1.delete(); coll_seen = 0;
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                enA = 1'b1; wenA = 1'b1; beA = 2'b11; AddressA = j[3:0]; WriteDataA = 16'(j);
            end else begin
                enA = 1'b0; wenA = 1'b0;
            end
            enB = (j >= 1 && j <= 16); AddressB = 4'(j - 1);
            tick();
            if (vB[0]) q0.push_back(rdB[0]);
            if (vB[1]) q1.push_back(rdB[1]);
            if (col[0] || col[1]) coll_seen++;
        end
        set_idle();
        tick();
        if (vB[1]) q1.push_back(rdB[1]);
        chk("sweep_count0", 16'(q0.size()), 16'd16);
        chk("sweep_count1", 16'(q1.size()), 16'd16);
        chk("sweep_collisions", 16'(coll_seen), 16'd0);
        for (int k = 0; k < 16; k++) begin
            if (k < q0.size()) chk($sformatf("sweep_data0_%0d", k), q0[k], 16'(k));
            if (k < q1.size()) chk($sformatf("sweep_data1_%0d", k), q1[k], 16'(k));
        end

        // Randomized traffic over a narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            enA = 1'($urandom); wenA = 1'($urandom); beA = 2'($urandom);
            AddressA = (i < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            WriteDataA = 16'($urandom);
            enB = 1'($urandom);
            AddressB = (i < 200) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            tick();
        end
        set_idle();
        tick();
        tick();

        // Reset in the middle of clearing: restart, and requests while busy are dropped.
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        do_reset();
        enA = 1'b1; wenA = 1'b1; beA = 2'b11; AddressA = 4'd3; WriteDataA = 16'hAAAA;
        enB = 1'b1; AddressB = 4'd3;
        wait_clear("reclear_cycles");
        set_idle();
        enA = 1'b1; AddressA = 4'd3;
        tick();
        chk("busy_write_dropped", rdA[0], 16'h0000);
        chk("busy_write_valid", {15'b0, vA[0]}, 16'h1);
        set_idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
